// File: rtl/mem_stage_unit.sv
// Memory-stage unit: sequences data-bus loads/stores and resolves branches.
// Optional performance counters are built when MEM_STAGE_PERF_EN is defined.
module mem_stage_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_MemRd,
    input  logic              mem_MemWr,
    input  logic [2:0]        mem_Load_sel,
    input  logic [1:0]        mem_Store_sel,
    input  logic [31:0]       mem_ALU_result,
    input  logic [31:0]       mem_readdata2,
    input  logic              mem_Branch,
    input  logic              mem_Jump,
    input  logic [1:0]        mem_BrOp,
    input  logic              mem_zero,
    input  logic              mem_lt,
    input  logic [31:0]       mem_pc,
    input  logic [31:0]       mem_pc_ori,
    input  logic              mem_predicted_bit,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_ack,
    input  logic [31:0]       dbus_rdata,
    output logic              mem_stall,
    output logic [31:0]       mem_load_data,
    output logic              mem_misalign,
    output logic              br_flush,
    output logic [31:0]       br_redirect_pc,
    output logic              br_update,
    output logic              br_taken
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_branch_cnt,
    output logic [31:0]       perf_mispred_cnt
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        loadSel_q, loadSel_d;

    logic        isAccess;
    logic        isHalf;
    logic        isWord;
    logic        misaligned;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] loadValue;
    logic        ackValid;
    logic        condOk;
    logic        taken;

    // Access width comes from the store or load selector depending on direction.
    always_comb begin
        isAccess = mem_MemRd | mem_MemWr;
        isHalf   = 1'b0;
        isWord   = 1'b0;
        if (mem_MemWr) begin
            isHalf = (mem_Store_sel == 2'b01);
            isWord = (mem_Store_sel == 2'b10);
        end else begin
            isHalf = (mem_Load_sel[1:0] == 2'b01);
            isWord = (mem_Load_sel[1:0] == 2'b10);
        end
        misaligned = isAccess & ((isHalf & mem_ALU_result[0]) |
                                 (isWord & (mem_ALU_result[1:0] != 2'b00)));
    end

    always_comb begin
        beNext    = 4'b0000;
        wdataNext = 32'd0;
        if (isWord) begin
            beNext    = 4'b1111;
            wdataNext = mem_readdata2;
        end else if (isHalf) begin
            beNext    = mem_ALU_result[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{mem_readdata2[15:0]}};
        end else begin
            beNext    = 4'b0001 << mem_ALU_result[1:0];
            wdataNext = {4{mem_readdata2[7:0]}};
        end
    end

    // Bus fields are captured once on issue and held for the whole BUSY phase.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        off_d     = off_q;
        loadSel_d = loadSel_q;
        case (state_q)
            IDLE: begin
                if (isAccess && !misaligned) begin
                    state_d   = BUSY;
                    req_d     = 1'b1;
                    we_d      = mem_MemWr;
                    addr_d    = ADDR_W'({mem_ALU_result[31:2], 2'b00});
                    be_d      = beNext;
                    wdata_d   = mem_MemWr ? wdataNext : 32'd0;
                    off_d     = mem_ALU_result[1:0];
                    loadSel_d = mem_Load_sel;
                end
            end
            default: begin
                if (dbus_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'd0;
            off_q     <= 2'b00;
            loadSel_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            off_q     <= off_d;
            loadSel_q <= loadSel_d;
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;

    always_comb begin
        selByte = dbus_rdata[7:0];
        case (off_q)
            2'd1:    selByte = dbus_rdata[15:8];
            2'd2:    selByte = dbus_rdata[23:16];
            2'd3:    selByte = dbus_rdata[31:24];
            default: selByte = dbus_rdata[7:0];
        endcase
        selHalf = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (loadSel_q)
            3'b000:  loadValue = {{24{selByte[7]}}, selByte};
            3'b001:  loadValue = {{16{selHalf[15]}}, selHalf};
            3'b100:  loadValue = {24'd0, selByte};
            3'b101:  loadValue = {16'd0, selHalf};
            default: loadValue = dbus_rdata;
        endcase
    end

    // Load data is only meaningful in the cycle the bus acknowledges a read.
    assign ackValid      = (state_q == BUSY) & dbus_ack;
    assign mem_load_data = (ackValid & !we_q) ? loadValue : 32'd0;
    assign mem_misalign  = misaligned;
    assign mem_stall     = (state_q == IDLE) ? (isAccess & !misaligned) : !dbus_ack;

    always_comb begin
        case (mem_BrOp)
            2'b00:   condOk = mem_zero;
            2'b01:   condOk = !mem_zero;
            2'b10:   condOk = mem_lt;
            default: condOk = !mem_lt;
        endcase
        taken = mem_Jump | (mem_Branch & condOk);
    end

    // Branch results are suppressed while a memory access holds the pipeline.
    assign br_update      = (mem_Branch | mem_Jump) & !mem_stall;
    assign br_taken       = br_update & taken;
    assign br_flush       = br_update & (taken != mem_predicted_bit);
    assign br_redirect_pc = br_flush ? (taken ? mem_pc : mem_pc_ori + 32'd4) : 32'd0;

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] brCnt_q;
    logic [31:0] misCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            brCnt_q  <= 32'd0;
            misCnt_q <= 32'd0;
        end else begin
            if (br_update) begin
                brCnt_q <= brCnt_q + 32'd1;
            end
            if (br_flush) begin
                misCnt_q <= misCnt_q + 32'd1;
            end
        end
    end

    assign perf_branch_cnt  = brCnt_q;
    assign perf_mispred_cnt = misCnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed cases plus randomized
// instructions compared every cycle against a transaction-level model.
module tb_mem_stage_unit;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_MemRd, mem_MemWr;
    logic [2:0]  mem_Load_sel;
    logic [1:0]  mem_Store_sel;
    logic [31:0] mem_ALU_result, mem_readdata2;
    logic        mem_Branch, mem_Jump;
    logic [1:0]  mem_BrOp;
    logic        mem_zero, mem_lt;
    logic [31:0] mem_pc, mem_pc_ori;
    logic        mem_predicted_bit;
    logic        dbus_req, dbus_we;
    logic [ADDR_W-1:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        mem_stall;
    logic [31:0] mem_load_data;
    logic        mem_misalign;
    logic        br_flush;
    logic [31:0] br_redirect_pc;
    logic        br_update, br_taken;
`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_branch_cnt, perf_mispred_cnt;
`endif

    always #5 clk = ~clk;

    mem_stage_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .mem_MemRd(mem_MemRd), .mem_MemWr(mem_MemWr),
        .mem_Load_sel(mem_Load_sel), .mem_Store_sel(mem_Store_sel),
        .mem_ALU_result(mem_ALU_result), .mem_readdata2(mem_readdata2),
        .mem_Branch(mem_Branch), .mem_Jump(mem_Jump), .mem_BrOp(mem_BrOp),
        .mem_zero(mem_zero), .mem_lt(mem_lt),
        .mem_pc(mem_pc), .mem_pc_ori(mem_pc_ori),
        .mem_predicted_bit(mem_predicted_bit),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .mem_stall(mem_stall), .mem_load_data(mem_load_data),
        .mem_misalign(mem_misalign),
        .br_flush(br_flush), .br_redirect_pc(br_redirect_pc),
        .br_update(br_update), .br_taken(br_taken)
`ifdef MEM_STAGE_PERF_EN
        , .perf_branch_cnt(perf_branch_cnt), .perf_mispred_cnt(perf_mispred_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    int modelBrCnt = 0;
    int modelMisCnt = 0;

    logic        expValid = 1'b0;
    logic        expStall, expReq, expWe, expMis, expUpd, expTaken, expFlush;
    logic [3:0]  expBe;
    logic [31:0] expAddr, expWdata, expLoad, expRedir;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Model: number of bytes moved by an access.
    function automatic int accSize(input logic wr, input logic [2:0] lsel, input logic [1:0] ssel);
        int s;
        if (wr) s = (ssel == 2'b00) ? 1 : (ssel == 2'b01) ? 2 : 4;
        else    s = (lsel == 3'b000 || lsel == 3'b100) ? 1 :
                    (lsel == 3'b001 || lsel == 3'b101) ? 2 : 4;
        return s;
    endfunction

    function automatic logic [3:0] modelBe(input int size, input int off);
        logic [3:0] m;
        int base;
        m = 4'b0000;
        base = off - (off % size);
        for (int i = 0; i < 4; i++) if (i >= base && i < base + size) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] modelWdata(input int size, input logic [31:0] d);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % size) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] lsel, input int off, input logic [31:0] rdata);
        logic [63:0] v, mask;
        int size;
        bit isSigned;
        size = accSize(1'b0, lsel, 2'b00);
        isSigned = (lsel == 3'b000 || lsel == 3'b001);
        mask = (64'd1 << (8 * size)) - 64'd1;
        v = ({32'd0, rdata} >> (8 * off)) & mask;
        if (isSigned && size < 4 && v[8*size-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic clearInputs();
        mem_MemRd = 0; mem_MemWr = 0; mem_Load_sel = 0; mem_Store_sel = 0;
        mem_ALU_result = 0; mem_readdata2 = 0; mem_Branch = 0; mem_Jump = 0;
        mem_BrOp = 0; mem_zero = 0; mem_lt = 0; mem_pc = 0; mem_pc_ori = 0;
        mem_predicted_bit = 0; dbus_ack = 0; dbus_rdata = 0;
    endtask

    task automatic clearExp();
        expValid = 1; expStall = 0; expReq = 0; expWe = 0; expMis = 0;
        expUpd = 0; expTaken = 0; expFlush = 0; expBe = 0; expAddr = 0;
        expWdata = 0; expLoad = 0; expRedir = 0;
    endtask

    // Per-cycle comparison of every output the model predicts.
    always @(negedge clk) begin
        if (expValid) begin
            checkOutput("stall", {31'd0, mem_stall}, {31'd0, expStall});
            checkOutput("req", {31'd0, dbus_req}, {31'd0, expReq});
            checkOutput("misalign", {31'd0, mem_misalign}, {31'd0, expMis});
            checkOutput("loadData", mem_load_data, expLoad);
            checkOutput("brUpdate", {31'd0, br_update}, {31'd0, expUpd});
            checkOutput("brTaken", {31'd0, br_taken}, {31'd0, expTaken});
            checkOutput("brFlush", {31'd0, br_flush}, {31'd0, expFlush});
            checkOutput("redirect", br_redirect_pc, expRedir);
            if (expReq) begin
                checkOutput("addr", dbus_addr, expAddr);
                checkOutput("we", {31'd0, dbus_we}, {31'd0, expWe});
                if (expWe) begin
                    checkOutput("be", {28'd0, dbus_be}, {28'd0, expBe});
                    checkOutput("wdata", dbus_wdata, expWdata);
                end
            end
        end
    end

    // One memory instruction held in MEM until its access completes.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] lsel,
                                 input logic [1:0] ssel, input logic [31:0] addr,
                                 input logic [31:0] data, input int waits,
                                 input logic [31:0] rdata, input logic earlyAck,
                                 output int stallCycles, output logic sawReq, output logic sawMis,
                                 output logic ackWe, output logic [3:0] ackBe,
                                 output logic [31:0] ackAddr, output logic [31:0] ackWdata,
                                 output logic [31:0] ackLoad);
        int size, off;
        bit mis;
        stallCycles = 0; sawReq = 0; sawMis = 0; ackWe = 0; ackBe = 0;
        ackAddr = 0; ackWdata = 0; ackLoad = 0;
        size = accSize(wr, lsel, ssel);
        off = int'(addr[1:0]);
        mis = (off % size) != 0;
        @(posedge clk); #1;
        clearInputs();
        mem_MemRd = rd; mem_MemWr = wr; mem_Load_sel = lsel; mem_Store_sel = ssel;
        mem_ALU_result = addr; mem_readdata2 = data;
        dbus_ack = earlyAck; dbus_rdata = $urandom;
        clearExp();
        expMis = mis;
        expStall = !mis;
        @(negedge clk);
        if (mem_stall) stallCycles++;
        if (dbus_req) sawReq = 1;
        if (mem_misalign) sawMis = 1;
        if (!mis) begin
            for (int w = 0; w <= waits; w++) begin
                @(posedge clk); #1;
                dbus_ack = (w == waits);
                dbus_rdata = (w == waits) ? rdata : $urandom;
                expReq = 1; expWe = wr; expAddr = {addr[31:2], 2'b00};
                expBe = modelBe(size, off); expWdata = modelWdata(size, data);
                expStall = (w != waits);
                expLoad = (w == waits && rd) ? modelLoad(lsel, off, rdata) : 32'd0;
                @(negedge clk);
                if (mem_stall) stallCycles++;
                if (dbus_req) sawReq = 1;
                if (w == waits) begin
                    ackWe = dbus_we; ackBe = dbus_be; ackAddr = dbus_addr;
                    ackWdata = dbus_wdata; ackLoad = mem_load_data;
                end
            end
        end
    endtask

    task automatic runBranch(input logic br, input logic jmp, input logic [1:0] op,
                             input logic z, input logic l, input logic [31:0] pc,
                             input logic [31:0] pcori, input logic pred,
                             output logic obsFlush, output logic [31:0] obsRedir);
        bit condOk, tk;
        @(posedge clk); #1;
        clearInputs();
        mem_Branch = br; mem_Jump = jmp; mem_BrOp = op; mem_zero = z; mem_lt = l;
        mem_pc = pc; mem_pc_ori = pcori; mem_predicted_bit = pred;
        dbus_ack = 1'($urandom_range(0, 1)); dbus_rdata = $urandom;
        case (op)
            2'b00: condOk = z;
            2'b01: condOk = !z;
            2'b10: condOk = l;
            default: condOk = !l;
        endcase
        tk = jmp || (br && condOk);
        clearExp();
        expUpd = br | jmp;
        expTaken = expUpd & tk;
        expFlush = expUpd & (tk != pred);
        expRedir = expFlush ? (tk ? pc : pcori + 32'd4) : 32'd0;
        if (expUpd) modelBrCnt++;
        if (expFlush) modelMisCnt++;
        @(negedge clk);
        obsFlush = br_flush; obsRedir = br_redirect_pc;
    endtask

    task automatic runIdle();
        @(posedge clk); #1;
        clearInputs();
        dbus_ack = 1'($urandom_range(0, 1)); dbus_rdata = $urandom;
        clearExp();
    endtask

    logic [2:0] loadSels [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [1:0] storeSels [3] = '{2'b00, 2'b01, 2'b10};

    initial begin
        int sc;
        logic sr, sm, aw, fl;
        logic [3:0] ab;
        logic [31:0] aa, awd, al, rd;
        logic [31:0] addr;

        clearInputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkOutput("rstReq", {31'd0, dbus_req}, 32'd0);
        checkOutput("rstWe", {31'd0, dbus_we}, 32'd0);
        checkOutput("rstBe", {28'd0, dbus_be}, 32'd0);
        checkOutput("rstAddr", dbus_addr, 32'd0);
        checkOutput("rstWdata", dbus_wdata, 32'd0);
        checkOutput("rstStall", {31'd0, mem_stall}, 32'd0);
        checkOutput("rstFlush", {31'd0, br_flush}, 32'd0);
        checkOutput("rstRedirect", br_redirect_pc, 32'd0);

        applyStimulus(1, 0, 3'b010, 2'b00, 32'h100, 0, 3, 32'hDEADBEEF, 1, sc, sr, sm, aw, ab, aa, awd, al);
        checkOutput("lwStallCycles", sc, 4);
        checkOutput("lwAddr", aa, 32'h100);
        checkOutput("lwBe", {28'd0, ab}, 32'hF);
        checkOutput("lwData", al, 32'hDEADBEEF);

        applyStimulus(1, 0, 3'b000, 2'b00, 32'h103, 0, 0, 32'h80FF0000, 0, sc, sr, sm, aw, ab, aa, awd, al);
        checkOutput("lbData", al, 32'hFFFFFF80);
        applyStimulus(1, 0, 3'b100, 2'b00, 32'h103, 0, 1, 32'h80FF0000, 0, sc, sr, sm, aw, ab, aa, awd, al);
        checkOutput("lbuData", al, 32'h00000080);

        applyStimulus(0, 1, 3'b000, 2'b01, 32'h102, 32'h1234ABCD, 0, 0, 0, sc, sr, sm, aw, ab, aa, awd, al);
        checkOutput("shWe", {31'd0, aw}, 32'd1);
        checkOutput("shBe", {28'd0, ab}, 32'hC);
        checkOutput("shWdata", awd, 32'hABCDABCD);

        applyStimulus(1, 0, 3'b010, 2'b00, 32'h101, 0, 0, 0, 0, sc, sr, sm, aw, ab, aa, awd, al);
        checkOutput("misFlag", {31'd0, sm}, 32'd1);
        checkOutput("misReq", {31'd0, sr}, 32'd0);
        checkOutput("misStall", sc, 0);

        runBranch(1, 0, 2'b00, 1, 0, 32'h200, 32'h40, 0, fl, rd);
        checkOutput("beqFlush", {31'd0, fl}, 32'd1);
        checkOutput("beqRedirect", rd, 32'h200);
        runBranch(1, 0, 2'b01, 1, 0, 32'h200, 32'h40, 1, fl, rd);
        checkOutput("bneFlush", {31'd0, fl}, 32'd1);
        checkOutput("bneRedirect", rd, 32'h44);

        @(posedge clk); #1;
        clearInputs();
        expValid = 0;
        mem_MemRd = 1; mem_Load_sel = 3'b010; mem_ALU_result = 32'h200;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("busyReq", {31'd0, dbus_req}, 32'd1);
        rst = 1; dbus_ack = 1; dbus_rdata = 32'h5555AAAA;
        @(posedge clk); #1;
        rst = 0;
        clearInputs();
        modelBrCnt = 0; modelMisCnt = 0;
        @(negedge clk);
        checkOutput("rstBusyReq", {31'd0, dbus_req}, 32'd0);
        checkOutput("rstBusyStall", {31'd0, mem_stall}, 32'd0);
        checkOutput("rstBusyAddr", dbus_addr, 32'd0);
`ifdef MEM_STAGE_PERF_EN
        checkOutput("rstPerfBr", perf_branch_cnt, 32'd0);
        checkOutput("rstPerfMis", perf_mispred_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        dbus_ack = 1; dbus_rdata = 32'h12345678;
        @(negedge clk);
        checkOutput("idleAckLoad", mem_load_data, 32'd0);
        checkOutput("idleAckStall", {31'd0, mem_stall}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                addr = $urandom;
                if ($urandom_range(0, 3) != 0) addr[0] = 1'b0;
                if ($urandom_range(0, 3) == 0) addr[1:0] = 2'b00;
                if ($urandom_range(0, 1) == 1)
                    applyStimulus(1, 0, loadSels[$urandom_range(0, 4)], 2'b00, addr, $urandom,
                                  $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
                                  sc, sr, sm, aw, ab, aa, awd, al);
                else
                    applyStimulus(0, 1, 3'b000, storeSels[$urandom_range(0, 2)], addr, $urandom,
                                  $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
                                  sc, sr, sm, aw, ab, aa, awd, al);
            end else if (kind <= 7) begin
                logic isJ;
                isJ = ($urandom_range(0, 3) == 0);
                runBranch(!isJ, isJ, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom, $urandom,
                          1'($urandom_range(0, 1)), fl, rd);
            end else begin
                runIdle();
            end
        end

        runIdle();
        @(negedge clk);
`ifdef MEM_STAGE_PERF_EN
        checkOutput("perfBranch", perf_branch_cnt, modelBrCnt);
        checkOutput("perfMispred", perf_mispred_cnt, modelMisCnt);
`endif
        expValid = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
